// File: rtl/character_motion_ctrl.sv
// Per-player sprite motion controller: once per video frame, steps position, facing,
// walk/jump/gravity physics and the animation frame index for the sprite renderer.
module character_motion_ctrl #(
    parameter int CHAR_WIDTH      = 40,
    parameter int CHAR_HEIGHT     = 50,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639,
    parameter int GROUND_Y        = 380,
    parameter int START_X         = 100,
    parameter int START_FACE_LEFT = 0,
    parameter int WALK_SPEED      = 3,
    parameter int JUMP_VEL        = 12,
    parameter int GRAVITY         = 1,
    parameter int MAX_FALL        = 12,
    parameter int ANIM_DIV        = 8
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       respawn,
    input  logic       freeze,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       jump,
    output logic [9:0] CharX,
    output logic [9:0] CharY,
    output logic       facing_left,
    output logic [1:0] anim_frame,
    output logic       grounded,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WALK = 2'd1;
    localparam logic [1:0] RISE = 2'd2;
    localparam logic [1:0] FALL = 2'd3;

    localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [ACW-1:0] ANIM_LAST = ACW'(ANIM_DIV - 1);

    localparam logic signed [10:0] X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] X_HI   = 11'(X_MAX - CHAR_WIDTH + 1);
    localparam logic signed [10:0] V_WALK = 11'(WALK_SPEED);
    localparam logic signed [10:0] Y_GND  = 11'(GROUND_Y);
    localparam logic signed [8:0]  V_GRAV = 9'(GRAVITY);
    localparam logic signed [8:0]  V_MAX  = 9'(MAX_FALL);
    localparam logic signed [7:0]  V_JUMP = 8'(GRAVITY - JUMP_VEL);

    // The standing sprite must fit within the 10-bit coordinate space.
    if (GROUND_Y + CHAR_HEIGHT > 1024) begin : g_param_check
        $error("character_motion_ctrl: GROUND_Y + CHAR_HEIGHT exceeds coordinate range");
    end

    logic signed [7:0]  vel_y;
    logic [ACW-1:0]     anim_cnt;
    logic               jump_armed;

    logic signed [10:0] dx, x_sum, y_new;
    logic signed [8:0]  v_sum;
    logic signed [7:0]  v_fall, v_nxt;
    logic [9:0]         x_nxt, y_nxt;
    logic [1:0]         st_nxt, walk_st, fr_nxt;
    logic [ACW-1:0]     cnt_nxt;
    logic               face_nxt, take_jump, armed_nxt;

    always_comb begin
        dx = '0;
        if (move_right && !move_left) begin
            dx = V_WALK;
        end else if (move_left && !move_right) begin
            dx = -V_WALK;
        end

        x_sum = $signed({1'b0, CharX}) + dx;
        if (x_sum < X_LO) begin
            x_nxt = X_LO[9:0];
        end else if (x_sum > X_HI) begin
            x_nxt = X_HI[9:0];
        end else begin
            x_nxt = x_sum[9:0];
        end

        face_nxt = facing_left;
        if (move_left && !move_right) begin
            face_nxt = 1'b1;
        end else if (move_right && !move_left) begin
            face_nxt = 1'b0;
        end

        walk_st = (dx != '0) ? WALK : IDLE;
        y_new   = $signed({1'b0, CharY}) + 11'(vel_y);
        v_sum   = 9'(vel_y) + V_GRAV;
        v_fall  = (v_sum > V_MAX) ? V_MAX[7:0] : v_sum[7:0];

        take_jump = 1'b0;
        y_nxt     = CharY;
        v_nxt     = vel_y;
        st_nxt    = state;

        if (!state[1]) begin
            if (jump && jump_armed) begin
                take_jump = 1'b1;
                y_nxt     = CharY - 10'(JUMP_VEL);
                v_nxt     = V_JUMP;
                st_nxt    = RISE;
            end else begin
                y_nxt  = Y_GND[9:0];
                v_nxt  = '0;
                st_nxt = walk_st;
            end
        end else begin
            if (y_new >= Y_GND) begin
                y_nxt  = Y_GND[9:0];
                v_nxt  = '0;
                st_nxt = walk_st;
            end else if (y_new < 11'sd0) begin
                y_nxt  = '0;
                v_nxt  = '0;
                st_nxt = FALL;
            end else begin
                y_nxt  = y_new[9:0];
                v_nxt  = v_fall;
                st_nxt = v_fall[7] ? RISE : FALL;
            end
        end

        armed_nxt = jump_armed;
        if (take_jump) begin
            armed_nxt = 1'b0;
        end else if (!jump) begin
            armed_nxt = 1'b1;
        end

        // Animation follows the state being entered on this tick.
        fr_nxt  = anim_frame;
        cnt_nxt = '0;
        case (st_nxt)
            WALK: begin
                if (anim_cnt == ANIM_LAST) begin
                    fr_nxt = anim_frame + 2'd1;
                end else begin
                    cnt_nxt = anim_cnt + ACW'(1);
                end
            end
            RISE:    fr_nxt = 2'd2;
            FALL:    fr_nxt = 2'd3;
            default: fr_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (Reset || respawn) begin
            CharX       <= 10'(START_X);
            CharY       <= 10'(GROUND_Y);
            vel_y       <= '0;
            state       <= IDLE;
            facing_left <= (START_FACE_LEFT != 0);
            anim_frame  <= '0;
            anim_cnt    <= '0;
            jump_armed  <= 1'b1;
            grounded    <= 1'b1;
        end else if (frame_tick && !freeze) begin
            CharX       <= x_nxt;
            CharY       <= y_nxt;
            vel_y       <= v_nxt;
            state       <= st_nxt;
            facing_left <= face_nxt;
            anim_frame  <= fr_nxt;
            anim_cnt    <= cnt_nxt;
            jump_armed  <= armed_nxt;
            grounded    <= !st_nxt[1];
        end
    end

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Bench for character_motion_ctrl: vector table, hand-written jump/freeze/respawn
// sequences, then randomized controls checked against a frame-level reference model.
module tb_character_motion_ctrl;

    localparam int P_CW     = 40;
    localparam int P_XMIN   = 0;
    localparam int P_XMAX   = 639;
    localparam int P_GND    = 380;
    localparam int P_STARTX = 100;
    localparam int P_WALK   = 3;
    localparam int P_JUMP   = 12;
    localparam int P_GRAV   = 1;
    localparam int P_MAXF   = 12;
    localparam int P_ADIV   = 8;

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b0, frame_tick = 1'b0, respawn = 1'b0, freeze = 1'b0;
    logic       move_left = 1'b0, move_right = 1'b0, jump = 1'b0;
    logic [9:0] CharX, CharY;
    logic       facing_left, grounded;
    logic [1:0] anim_frame, state;

    character_motion_ctrl #(
        .CHAR_WIDTH(P_CW), .CHAR_HEIGHT(50), .X_MIN(P_XMIN), .X_MAX(P_XMAX),
        .GROUND_Y(P_GND), .START_X(P_STARTX), .START_FACE_LEFT(0),
        .WALK_SPEED(P_WALK), .JUMP_VEL(P_JUMP), .GRAVITY(P_GRAV),
        .MAX_FALL(P_MAXF), .ANIM_DIV(P_ADIV)
    ) dut (
        .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick), .respawn(respawn),
        .freeze(freeze), .move_left(move_left), .move_right(move_right), .jump(jump),
        .CharX(CharX), .CharY(CharY), .facing_left(facing_left),
        .anim_frame(anim_frame), .grounded(grounded), .state(state)
    );

    always #5 vga_clk = ~vga_clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int x, y, v, st, face, fr, cnt, armed;
    } mdl_t;

    typedef struct {
        logic rst, resp, tick, frz, l, r, j;
        int ex, ey, est, eface, efr, egnd;
    } vec_t;

    mdl_t m;
    vec_t vecs[16];

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.x = P_STARTX; n.y = P_GND; n.v = 0; n.st = 0;
        n.face = 0; n.fr = 0; n.cnt = 0; n.armed = 1;
        return n;
    endfunction

    // One video frame of the character's physics, in plain integer arithmetic.
    function automatic mdl_t mdl_step(mdl_t c, bit rst, bit resp, bit tick, bit frz,
                                      bit l, bit r, bit j);
        mdl_t n;
        int dx, yn, xmax;
        bit took;
        if (rst || resp) return mdl_reset();
        if (!tick || frz) return c;
        n = c;
        took = 0;
        xmax = P_XMAX - P_CW + 1;
        dx = (r && !l) ? P_WALK : ((l && !r) ? -P_WALK : 0);
        n.x = c.x + dx;
        if (n.x < P_XMIN) n.x = P_XMIN;
        if (n.x > xmax) n.x = xmax;
        if (l && !r) n.face = 1;
        else if (r && !l) n.face = 0;
        if (c.st < 2) begin
            if (j && c.armed) begin
                took = 1; n.v = -(P_JUMP - P_GRAV); n.y = c.y - P_JUMP; n.st = 2;
            end else begin
                n.y = P_GND; n.v = 0; n.st = (dx != 0) ? 1 : 0;
            end
        end else begin
            yn = c.y + c.v;
            if (yn >= P_GND) begin
                n.y = P_GND; n.v = 0; n.st = (dx != 0) ? 1 : 0;
            end else if (yn < 0) begin
                n.y = 0; n.v = 0; n.st = 3;
            end else begin
                n.y = yn;
                n.v = (c.v + P_GRAV > P_MAXF) ? P_MAXF : c.v + P_GRAV;
                n.st = (n.v < 0) ? 2 : 3;
            end
        end
        if (took) n.armed = 0;
        else if (!j) n.armed = 1;
        case (n.st)
            1: begin
                if (c.cnt == P_ADIV - 1) begin
                    n.cnt = 0; n.fr = (c.fr + 1) % 4;
                end else begin
                    n.cnt = c.cnt + 1;
                end
            end
            2: begin n.fr = 2; n.cnt = 0; end
            3: begin n.fr = 3; n.cnt = 0; end
            default: begin n.fr = 0; n.cnt = 0; end
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit rst, input bit resp, input bit tick, input bit frz,
                         input bit l, input bit r, input bit j);
        Reset = rst; respawn = resp; frame_tick = tick; freeze = frz;
        move_left = l; move_right = r; jump = j;
        @(posedge vga_clk);
        m = mdl_step(m, rst, resp, tick, frz, l, r, j);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".x"}, int'(CharX), m.x);
        chk({tag, ".y"}, int'(CharY), m.y);
        chk({tag, ".st"}, int'(state), m.st);
        chk({tag, ".face"}, int'(facing_left), m.face);
        chk({tag, ".fr"}, int'(anim_frame), m.fr);
        chk({tag, ".gnd"}, int'(grounded), (m.st < 2) ? 1 : 0);
    endtask

    task automatic setv(input int i, input bit rst, input bit resp, input bit tick,
                        input bit frz, input bit l, input bit r, input bit j,
                        input int ex, input int ey, input int est, input int eface,
                        input int efr, input int egnd);
        vecs[i].rst = rst; vecs[i].resp = resp; vecs[i].tick = tick; vecs[i].frz = frz;
        vecs[i].l = l; vecs[i].r = r; vecs[i].j = j;
        vecs[i].ex = ex; vecs[i].ey = ey; vecs[i].est = est;
        vecs[i].eface = eface; vecs[i].efr = efr; vecs[i].egnd = egnd;
    endtask

    bit rr, rp, tk, fz, jh, kl, kr;

    initial begin
        m = mdl_reset();

        setv(0, 1, 0, 0, 0, 0, 0, 0, 100, 380, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++)
            setv(k, 0, 0, 1, 0, 0, 1, 0, 100 + 3 * k, 380, 1, 0, (k >= 8) ? 1 : 0, 1);
        setv(11, 0, 0, 1, 0, 1, 1, 0, 130, 380, 0, 0, 0, 1);
        setv(12, 0, 0, 1, 0, 1, 0, 0, 127, 380, 1, 1, 0, 1);
        setv(13, 0, 0, 1, 1, 1, 0, 0, 127, 380, 1, 1, 0, 1);
        setv(14, 0, 0, 0, 0, 1, 0, 0, 127, 380, 1, 1, 0, 1);
        setv(15, 1, 0, 1, 0, 1, 0, 0, 100, 380, 0, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].resp, vecs[i].tick, vecs[i].frz,
                  vecs[i].l, vecs[i].r, vecs[i].j);
            chk($sformatf("vec%0d.x", i), int'(CharX), vecs[i].ex);
            chk($sformatf("vec%0d.y", i), int'(CharY), vecs[i].ey);
            chk($sformatf("vec%0d.st", i), int'(state), vecs[i].est);
            chk($sformatf("vec%0d.face", i), int'(facing_left), vecs[i].eface);
            chk($sformatf("vec%0d.fr", i), int'(anim_frame), vecs[i].efr);
            chk($sformatf("vec%0d.gnd", i), int'(grounded), vecs[i].egnd);
        end

        // Right-edge clamp: 100 + 163*3 = 589, then 592, 595, 598, 600, 600.
        for (int k = 0; k < 163; k++) drive(0, 0, 1, 0, 0, 1, 0);
        chk("clamp.start", int'(CharX), 589);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 0, 0, 1, 0);
            chk($sformatf("clamp.x%0d", k), int'(CharX), (k < 3) ? 592 + 3 * k : 600);
        end
        drive(0, 0, 1, 0, 1, 1, 0);
        chk("both.x", int'(CharX), 600);
        chk("both.st", int'(state), 0);
        chk("both.face", int'(facing_left), 0);

        // Jump held for 30 frames: single jump, apex at 12, landing at 25.
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int t = 1; t <= 30; t++) begin
            drive(0, 0, 1, 0, 0, 0, 1);
            if (t == 1) begin
                chk("jump1.y", int'(CharY), 368);
                chk("jump1.st", int'(state), 2);
                chk("jump1.fr", int'(anim_frame), 2);
                chk("jump1.gnd", int'(grounded), 0);
            end
            if (t == 12) begin
                chk("apex.y", int'(CharY), 302);
                chk("apex.st", int'(state), 3);
                chk("apex.fr", int'(anim_frame), 3);
            end
            if (t == 24) chk("t24.y", int'(CharY), 368);
            if (t == 25) begin
                chk("land.y", int'(CharY), 380);
                chk("land.st", int'(state), 0);
                chk("land.gnd", int'(grounded), 1);
                chk("land.fr", int'(anim_frame), 0);
            end
            if (t > 25) chk($sformatf("held%0d.st", t), int'(state), 0);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("rel.st", int'(state), 0);
        drive(0, 0, 1, 0, 0, 0, 1);
        chk("rejump.y", int'(CharY), 368);
        chk("rejump.st", int'(state), 2);
        drive(0, 0, 1, 0, 0, 0, 1);
        chk("rise2.y", int'(CharY), 357);

        // Freeze mid-air: nothing moves, then the trajectory resumes.
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 1, 1, 0, 1, 1);
            chk($sformatf("frz%0d.y", k), int'(CharY), 357);
            chk($sformatf("frz%0d.x", k), int'(CharX), 100);
        end
        drive(0, 0, 1, 0, 0, 0, 1);
        chk("resume.y", int'(CharY), 347);
        chk("resume.st", int'(state), 2);

        // Respawn while airborne with a coincident frame tick.
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 0, 1, 0);
        chk("air.x", int'(CharX), 109);
        chk("air.y", int'(CharY), 323);
        drive(0, 1, 1, 0, 0, 1, 0);
        chk("resp.x", int'(CharX), 100);
        chk("resp.y", int'(CharY), 380);
        chk("resp.st", int'(state), 0);
        chk("resp.fr", int'(anim_frame), 0);
        chk("resp.gnd", int'(grounded), 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("post.y", int'(CharY), 380);
        chk("post.st", int'(state), 0);

        // Randomized controls against the reference model.
        jh = 0; kl = 0; kr = 0;
        for (int n = 0; n < 4000; n++) begin
            rr = ($urandom_range(0, 299) == 0);
            rp = ($urandom_range(0, 99) == 0);
            tk = ($urandom_range(0, 2) != 0);
            fz = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) jh = ~jh;
            if ($urandom_range(0, 7) == 0) begin
                kl = ($urandom_range(0, 1) == 1);
                kr = ($urandom_range(0, 1) == 1);
            end
            drive(rr, rp, tk, fz, kl, kr, jh);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
